// File: rtl/counter_seq_ctrl_if.sv
// Signal bundle between the sweep sequencer and its surroundings (divider tick,
// user start/stop, range bounds, counter feedback and counter control outputs).
interface counter_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    // Protocol: start is a level sampled on every clk edge and is accepted only in IDLE.
    // tick is a one-clk strobe; counter and sequencer both advance on edges where tick=1.
    logic             tick;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] count_in;
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       state;

    modport master (
        output tick, start, stop, start_val, end_val, count_in,
        input  enable, up_down, load, data_in, busy, done, err, state
    );

    modport slave (
        input  tick, start, stop, start_val, end_val, count_in,
        output enable, up_down, load, data_in, busy, done, err, state
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sweeps an external up/down counter between a latched start and end value,
// dwelling at each end, for LOOPS round trips (LOOPS=0 runs until stop).
module counter_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int HOLD_TICKS = 3,
    parameter int LOOPS      = 2
) (
    input logic               clk,
    input logic               rst,
    counter_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_UP       = 3'd2,
        S_HOLD_TOP = 3'd3,
        S_DOWN     = 3'd4,
        S_HOLD_BOT = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       loop_q, loop_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] end_m1;
    logic [WIDTH-1:0] start_p1;
    logic [7:0]       hold_inc;
    logic [7:0]       loop_inc;
    logic             hold_last;

    // start < end is guaranteed once latched, so neither neighbour wraps.
    assign end_m1    = end_q - WIDTH'(1);
    assign start_p1  = start_q + WIDTH'(1);
    assign hold_inc  = hold_q + 8'd1;
    assign loop_inc  = loop_q + 8'd1;
    assign hold_last = (hold_inc == 8'(HOLD_TICKS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= '0;
            end_q   <= '0;
            hold_q  <= '0;
            loop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            hold_q  <= hold_d;
            loop_q  <= loop_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        end_d   = end_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        err_d   = 1'b0;
        if (state_q != S_IDLE && bus.stop) begin
            state_d = S_IDLE;
            loop_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (bus.start_val < bus.end_val) begin
                            start_d = bus.start_val;
                            end_d   = bus.end_val;
                            loop_d  = '0;
                            state_d = S_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_LOAD: if (bus.tick) state_d = S_UP;
                S_UP: begin
                    if (bus.tick && bus.count_in == end_m1) begin
                        hold_d  = '0;
                        state_d = S_HOLD_TOP;
                    end
                end
                S_HOLD_TOP: begin
                    if (bus.tick) begin
                        hold_d = hold_inc;
                        if (hold_last) state_d = S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (bus.tick && bus.count_in == start_p1) begin
                        hold_d  = '0;
                        state_d = S_HOLD_BOT;
                    end
                end
                S_HOLD_BOT: begin
                    if (bus.tick) begin
                        hold_d = hold_inc;
                        if (hold_last) begin
                            // Loop count only matters for a finite sweep.
                            if (LOOPS != 0) loop_d = loop_inc;
                            if (LOOPS != 0 && loop_inc == 8'(LOOPS)) state_d = S_DONE;
                            else                                      state_d = S_UP;
                        end
                    end
                end
                S_DONE: begin
                    loop_d  = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    logic enable_o, up_down_o, load_o, busy_o, done_o;

    always_comb begin
        enable_o  = 1'b0;
        up_down_o = 1'b1;
        load_o    = 1'b0;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        case (state_q)
            S_IDLE:     busy_o = 1'b0;
            S_LOAD:     begin load_o = 1'b1; enable_o = 1'b1; end
            S_UP:       enable_o = 1'b1;
            S_HOLD_TOP: enable_o = 1'b0;
            S_DOWN:     begin enable_o = 1'b1; up_down_o = 1'b0; end
            S_HOLD_BOT: up_down_o = 1'b0;
            S_DONE:     done_o = 1'b1;
            default:    busy_o = 1'b0;
        endcase
    end

    assign bus.enable  = enable_o;
    assign bus.up_down = up_down_o;
    assign bus.load    = load_o;
    assign bus.busy    = busy_o;
    assign bus.done    = done_o;
    assign bus.err     = err_q;
    assign bus.data_in = start_q;
    assign bus.state   = state_q;

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencing controller for the up/down counter and 7-segment display path. It drives the counter's enable, up_down, load and data_in so the counter sweeps a programmable range: load a start value, count up to an end value, dwell, count down to the start, dwell, then repeat for a set number of loops. Controller and counter share one clk. The counter updates only on cycles where the divider's tick strobe is 1, and the controller advances on the same ticks. The counter's count output is fed back so the controller can detect the range ends.

Parameters:
WIDTH, 4, width of count, data_in, start_val, end_val
HOLD_TICKS, 3, dwell length in ticks at each end of the range; legal range 1..255
LOOPS, 2, number of full up/down loops before completion; 0 = run until stop

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tick  input  1  one-clk strobe from clock divider; counter updates on clk edges where tick=1
start  input  1  level, sampled each clk; begins a sequence when in IDLE
stop  input  1  level; aborts the sequence
start_val  input  WIDTH  range low bound, latched on accepted start
end_val  input  WIDTH  range high bound, latched on accepted start
count_in  input  WIDTH  counter value feedback
enable  output  1  counter enable
up_down  output  1  1 = count up, 0 = count down
load  output  1  counter synchronous load
data_in  output  WIDTH  counter load value; always equals latched start value
busy  output  1  high in every state except IDLE
done  output  1  one-clk pulse on completion
err  output  1  one-clk pulse on rejected start
state  output  3  current FSM state encoding, for debug

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; latches, loop and hold counters = 0.
- Reset output values: enable=0, load=0, up_down=1, data_in=0, busy=0, done=0, err=0.
- Reset wins over all other inputs, including mid-sequence.
- Outputs are Moore, decoded from registered state. No combinational path from any input to any output.
- States and transitions (all evaluated at clk edges):
- IDLE: enable=0.
  - start=1 and start_val<end_val: latch both values, go to LOAD.
  - start=1 and start_val>=end_val: err=1 next cycle, stay in IDLE, latches unchanged.
- LOAD: load=1, enable=1. On tick go to UP; the counter loads start on that tick.
- UP: enable=1, up_down=1. On a tick with count_in==end-1, go to HOLD_TOP. The counter reaches end on that same tick, so it never overshoots.
- HOLD_TOP: enable=0. Hold counter clears on entry and increments on each tick. After HOLD_TICKS ticks, go to DOWN.
- DOWN: enable=1, up_down=0. On a tick with count_in==start+1, go to HOLD_BOT.
- HOLD_BOT: enable=0, up_down=0. After HOLD_TICKS ticks, increment loop_cnt.
  - If LOOPS!=0 and the new loop_cnt==LOOPS: go to DONE.
  - Otherwise go to UP.
- DONE: enable=0, done=1 for exactly one clk, then IDLE. loop_cnt clears on IDLE entry.
- Non-tick cycles never change the state, except for start/stop handling and the single-cycle DONE.
- stop=1 in any non-IDLE state: IDLE on the next edge. No done pulse; count is left frozen. stop has priority over tick-driven transitions.
- stop=1 in IDLE with start=1: the start is ignored.
- start while busy is ignored. Latched values are stable for the whole sequence; start_val/end_val changes mid-sequence have no effect.
- end==start+1:
  - UP exits on its first tick (count_in==start).
  - DOWN exits on its first tick (count_in==end).
- Equality compares are WIDTH-bit unsigned. end-1 and start+1 do not wrap because start<end is guaranteed.
- Loop counter is 8 bits and is unused when LOOPS=0.
- State encoding: IDLE=0, LOAD=1, UP=2, HOLD_TOP=3, DOWN=4, HOLD_BOT=5, DONE=6.

Test Plan:
- Basic sweep. Config: LOOPS=1, HOLD_TICKS=3, start_val=2, end_val=5, tick every 4 clk, counter model attached. Stimulus: one start pulse.
  - Count per tick: 2,3,4,5,5,5,5,4,3,2,2,2,2.
  - done pulses exactly once, at the end; busy high from the edge after start until DONE exits.
- Looping. Config: LOOPS=2, same stimulus as the basic sweep.
  - The full pattern repeats twice; done pulses once, after the second HOLD_BOT.
  - With LOOPS=0: still sweeping after 10 loops, done never asserted.
- Rejected start: start_val=7, end_val=7, then start_val=9, end_val=3.
  - Each gives a single err pulse; state stays 0; enable stays 0.
- Abort. Stop asserted in UP at count=4.
  - Next clk: state=IDLE, enable=0, busy=0, no done, count holds 4.
  - A new start reloads start_val.
- Minimum range: start_val=0, end_val=1.
  - Count per tick: 0,1, hold for HOLD_TICKS ticks, then 0; correct done.
  - tick held at 1 every clk gives identical behaviour.
- Reset mid-HOLD_TOP: rst pulsed for 1 clk.
  - All outputs return to reset values on the next edge.
  - Start while busy and start/end changes mid-run have no effect (checked in the same run).
